// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between a core memory stage and a synchronous word-wide data memory.
// Handles alignment/range faults, sb/sh read-modify-write, and lb/lh/lbu/lhu extension.
module mem_access_ctrl #(
    parameter int DEPTH_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Req,
    input  logic        Write,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Address,
    input  logic [31:0] StoreData,
    output logic        Ready,
    output logic        Done,
    output logic        Fault,
    output logic [31:0] LoadData,
    output logic [31:0] MemAddress,
    output logic [31:0] MemDataIn,
    output logic        MemReadEnable,
    output logic        MemWriteEnable,
    input  logic [31:0] MemDataOut
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RDWAIT,
        S_WR,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [DEPTH_W+1:0]   addr_q;
    logic                 write_q;
    logic [2:0]           funct3_q;
    logic [31:0]          wdata_q;
    logic [31:0]          load_q;
    logic                 fault_q;

    logic                 req_fault;
    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic [31:0]          load_ext;
    logic [31:0]          merged;

    assign req_fault = (Funct3 == 3'b011) || (Funct3[2:1] == 2'b11)
                     || (Write && Funct3[2])
                     || ((Funct3[1:0] == 2'b01) && Address[0])
                     || ((Funct3[1:0] == 2'b10) && (Address[1:0] != 2'b00))
                     || (|Address[31:DEPTH_W+2]);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    if (req_fault)
                        state_d = S_DONE;
                    else if (Write && (Funct3 == 3'b010))
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD:     state_d = S_RDWAIT;
            S_RDWAIT: state_d = write_q ? S_WR : S_DONE;
            S_WR:     state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    assign byte_sel = MemDataOut[{addr_q[1:0], 3'b000} +: 8];
    assign half_sel = addr_q[1] ? MemDataOut[31:16] : MemDataOut[15:0];

    // funct3[2] selects zero extension for lbu/lhu
    always_comb begin
        load_ext = MemDataOut;
        case (funct3_q[1:0])
            2'b00:   load_ext = {{24{byte_sel[7] & ~funct3_q[2]}}, byte_sel};
            2'b01:   load_ext = {{16{half_sel[15] & ~funct3_q[2]}}, half_sel};
            default: load_ext = MemDataOut;
        endcase
    end

    // Per-lane merge: sb replaces one lane with the low byte, sh replaces a lane pair
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic lane_hit;
            assign lane_hit = (funct3_q[1:0] == 2'b00) ? (addr_q[1:0] == 2'(gi))
                                                       : (addr_q[1] == 1'(gi / 2));
            assign merged[8*gi +: 8] = lane_hit
                ? (funct3_q[0] ? wdata_q[8*(gi%2) +: 8] : wdata_q[7:0])
                : MemDataOut[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            wdata_q  <= 32'h0;
            load_q   <= 32'h0;
            fault_q  <= 1'b0;
        end else begin
            if ((state_q == S_IDLE) && Req) begin
                addr_q   <= Address[DEPTH_W+1:0];
                write_q  <= Write;
                funct3_q <= Funct3;
                wdata_q  <= StoreData;
                fault_q  <= req_fault;
            end
            if (state_q == S_RDWAIT) begin
                if (write_q)
                    wdata_q <= merged;
                else
                    load_q <= load_ext;
            end
        end
    end

    assign Ready          = (state_q == S_IDLE);
    assign Done           = (state_q == S_DONE);
    assign Fault          = Done && fault_q;
    assign LoadData       = load_q;
    assign MemReadEnable  = (state_q == S_RD);
    assign MemWriteEnable = (state_q == S_WR);
    assign MemAddress     = Ready ? 32'h0 : {{(32-DEPTH_W){1'b0}}, addr_q[DEPTH_W+1:2]};
    assign MemDataIn      = Ready ? 32'h0 : wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a 256-word synchronous memory model.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        Ready, Done, Fault;
    logic [31:0] LoadData, MemAddress, MemDataIn;
    logic        MemReadEnable, MemWriteEnable;
    logic [31:0] MemDataOut;

    logic [31:0] mem [0:255];
    logic        preload;

    int checks = 0;
    int errors = 0;

    int          o_lat, rd_cnt, wr_cnt, rd_cyc, wr_cyc;
    logic        o_flt, ovl;
    logic [31:0] wr_a, wr_d;

    mem_access_ctrl #(.DEPTH_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .Req(req),
        .Write(wr),
        .Funct3(f3),
        .Address(addr),
        .StoreData(sdata),
        .Ready(Ready),
        .Done(Done),
        .Fault(Fault),
        .LoadData(LoadData),
        .MemAddress(MemAddress),
        .MemDataIn(MemDataIn),
        .MemReadEnable(MemReadEnable),
        .MemWriteEnable(MemWriteEnable),
        .MemDataOut(MemDataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= i;
            MemDataOut <= 32'h0;
        end else begin
            if (MemWriteEnable) mem[MemAddress[7:0]] <= MemDataIn;
            if (MemReadEnable)  MemDataOut <= mem[MemAddress[7:0]];
        end
    end

    // Issues one request from the posedge+1 phase and records what the DUT does until Done.
    task automatic run_access(input logic w, input logic [2:0] f, input logic [31:0] a,
                              input logic [31:0] d);
        int guard;
        guard = 0;
        o_lat = -1; o_flt = 1'b0; rd_cnt = 0; wr_cnt = 0; rd_cyc = -1; wr_cyc = -1;
        wr_a = 32'h0; wr_d = 32'h0; ovl = 1'b0;
        while (!Ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        req = 1'b1; wr = w; f3 = f; addr = a; sdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (MemReadEnable) begin rd_cnt++; rd_cyc = c; end
            if (MemWriteEnable) begin wr_cnt++; wr_cyc = c; wr_a = MemAddress; wr_d = MemDataIn; end
            if (MemReadEnable && MemWriteEnable) ovl = 1'b1;
            if (Done) begin o_lat = c; o_flt = Fault; break; end
            @(posedge clk); #1;
        end
        $display("access w=%0b f3=%03b addr=%08h sd=%08h -> lat=%0d fault=%0b rd=%0d wr=%0d wdata=%08h load=%08h",
                 w, f, a, d, o_lat, o_flt, rd_cnt, wr_cnt, wr_d, LoadData);
    endtask

    task automatic test_reset;
        checks++; if (Ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", Ready); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", Done); end
        checks++; if (Fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %0b expected 0", Fault); end
        checks++; if (LoadData !== 32'h0) begin errors++; $display("FAIL reset_loaddata: got %08h expected 0", LoadData); end
        checks++; if (MemReadEnable !== 1'b0 || MemWriteEnable !== 1'b0) begin
            errors++; $display("FAIL reset_strobes: got re=%0b we=%0b expected 0 0", MemReadEnable, MemWriteEnable); end
        checks++; if (MemAddress !== 32'h0 || MemDataIn !== 32'h0) begin
            errors++; $display("FAIL reset_mem_bus: got addr=%08h din=%08h expected 0 0", MemAddress, MemDataIn); end
    endtask

    task automatic test_round_trip;
        run_access(1'b1, 3'b010, 32'h28, 32'hDEADBEEF);
        checks++; if (o_lat !== 2 || o_flt !== 1'b0) begin
            errors++; $display("FAIL sw_done: got lat=%0d fault=%0b expected 2 0", o_lat, o_flt); end
        checks++; if (wr_cnt !== 1 || wr_cyc !== 1 || rd_cnt !== 0) begin
            errors++; $display("FAIL sw_strobes: got wr=%0d@%0d rd=%0d expected wr=1@1 rd=0", wr_cnt, wr_cyc, rd_cnt); end
        checks++; if (wr_a !== 32'd10 || wr_d !== 32'hDEADBEEF) begin
            errors++; $display("FAIL sw_bus: got addr=%0d din=%08h expected 10 deadbeef", wr_a, wr_d); end
        @(posedge clk); #1;
        checks++; if (Ready !== 1'b1 || MemAddress !== 32'h0 || MemDataIn !== 32'h0) begin
            errors++; $display("FAIL idle_bus: got ready=%0b addr=%08h din=%08h expected 1 0 0", Ready, MemAddress, MemDataIn); end
        run_access(1'b0, 3'b010, 32'h28, 32'h0);
        checks++; if (o_lat !== 3 || o_flt !== 1'b0) begin
            errors++; $display("FAIL lw_done: got lat=%0d fault=%0b expected 3 0", o_lat, o_flt); end
        checks++; if (rd_cnt !== 1 || rd_cyc !== 1 || wr_cnt !== 0) begin
            errors++; $display("FAIL lw_strobes: got rd=%0d@%0d wr=%0d expected rd=1@1 wr=0", rd_cnt, rd_cyc, wr_cnt); end
        checks++; if (LoadData !== 32'hDEADBEEF) begin
            errors++; $display("FAIL lw_data: got %08h expected deadbeef", LoadData); end
    endtask

    task automatic test_extension;
        logic [2:0]  tf [4]  = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ta [4]  = '{32'h2B, 32'h2B, 32'h2A, 32'h28};
        logic [31:0] te [4]  = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
        for (int i = 0; i < 4; i++) begin
            run_access(1'b0, tf[i], ta[i], 32'h0);
            checks++; if (o_lat !== 3 || LoadData !== te[i]) begin
                errors++; $display("FAIL ext_%0d: got lat=%0d data=%08h expected 3 %08h", i, o_lat, LoadData, te[i]); end
        end
    endtask

    task automatic test_partial_store;
        run_access(1'b1, 3'b000, 32'h29, 32'hFFFFFF55);
        checks++; if (o_lat !== 4 || o_flt !== 1'b0) begin
            errors++; $display("FAIL sb_done: got lat=%0d fault=%0b expected 4 0", o_lat, o_flt); end
        checks++; if (rd_cyc !== 1 || wr_cyc !== 3 || rd_cnt !== 1 || wr_cnt !== 1 || ovl !== 1'b0) begin
            errors++; $display("FAIL sb_strobes: got rd=%0d@%0d wr=%0d@%0d ovl=%0b expected 1@1 1@3 0",
                               rd_cnt, rd_cyc, wr_cnt, wr_cyc, ovl); end
        checks++; if (wr_a !== 32'd10 || wr_d !== 32'hDEAD55EF) begin
            errors++; $display("FAIL sb_merge: got addr=%0d din=%08h expected 10 dead55ef", wr_a, wr_d); end
        run_access(1'b1, 3'b001, 32'h2A, 32'hABCD1234);
        checks++; if (o_lat !== 4 || wr_d !== 32'h123455EF) begin
            errors++; $display("FAIL sh_merge: got lat=%0d din=%08h expected 4 123455ef", o_lat, wr_d); end
        run_access(1'b0, 3'b010, 32'h28, 32'h0);
        checks++; if (LoadData !== 32'h123455EF) begin
            errors++; $display("FAIL partial_readback: got %08h expected 123455ef", LoadData); end
    endtask

    task automatic test_faults;
        logic        tw [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  tf [5] = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b100};
        logic [31:0] ta [5] = '{32'h2A, 32'h29, 32'h28, 32'h400, 32'h28};
        for (int i = 0; i < 5; i++) begin
            run_access(tw[i], tf[i], ta[i], 32'h77777777);
            checks++; if (o_lat !== 1 || o_flt !== 1'b1) begin
                errors++; $display("FAIL fault_%0d_done: got lat=%0d fault=%0b expected 1 1", i, o_lat, o_flt); end
            checks++; if (rd_cnt !== 0 || wr_cnt !== 0) begin
                errors++; $display("FAIL fault_%0d_strobes: got rd=%0d wr=%0d expected 0 0", i, rd_cnt, wr_cnt); end
            checks++; if (LoadData !== 32'h123455EF) begin
                errors++; $display("FAIL fault_%0d_loaddata: got %08h expected 123455ef", i, LoadData); end
        end
        run_access(1'b0, 3'b010, 32'h2C, 32'h0);
        checks++; if (o_flt !== 1'b0 || LoadData !== 32'h0000000B) begin
            errors++; $display("FAIL post_fault_lw: got fault=%0b data=%08h expected 0 0000000b", o_flt, LoadData); end
    endtask

    task automatic test_reset_abort;
        int stray;
        stray = 0;
        req = 1'b1; wr = 1'b1; f3 = 3'b000; addr = 32'h0C; sdata = 32'h000000AA;
        @(posedge clk); #1;
        req = 1'b0;
        checks++; if (MemReadEnable !== 1'b1) begin
            errors++; $display("FAIL abort_rd: got re=%0b expected 1", MemReadEnable); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (Ready !== 1'b1 || Done !== 1'b0 || Fault !== 1'b0) begin
            errors++; $display("FAIL abort_ctrl: got ready=%0b done=%0b fault=%0b expected 1 0 0", Ready, Done, Fault); end
        checks++; if (MemReadEnable !== 1'b0 || MemWriteEnable !== 1'b0) begin
            errors++; $display("FAIL abort_strobes: got re=%0b we=%0b expected 0 0", MemReadEnable, MemWriteEnable); end
        checks++; if (MemAddress !== 32'h0 || MemDataIn !== 32'h0 || LoadData !== 32'h0) begin
            errors++; $display("FAIL abort_bus: got addr=%08h din=%08h ld=%08h expected 0 0 0", MemAddress, MemDataIn, LoadData); end
        repeat (2) begin
            @(posedge clk); #1;
            if (Done || MemWriteEnable || MemReadEnable) stray++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (Done || MemWriteEnable || MemReadEnable) stray++;
        end
        checks++; if (stray !== 0) begin
            errors++; $display("FAIL abort_no_done: got %0d stray strobe cycles expected 0", stray); end
        checks++; if (mem[3] !== 32'h00000003) begin
            errors++; $display("FAIL abort_word3: got %08h expected 00000003", mem[3]); end
        run_access(1'b0, 3'b010, 32'h0C, 32'h0);
        checks++; if (o_lat !== 3 || LoadData !== 32'h00000003) begin
            errors++; $display("FAIL abort_reload: got lat=%0d data=%08h expected 3 00000003", o_lat, LoadData); end
    endtask

    task automatic test_back_to_back;
        int nacc, ndone, acc1, acc2, done1, done2;
        logic rdy;
        logic [31:0] ld1, ld2;
        logic overlap;
        nacc = 0; ndone = 0; acc1 = -1; acc2 = -1; done1 = -1; done2 = -1;
        ld1 = 32'h0; ld2 = 32'h0; overlap = 1'b0;
        @(posedge clk); #1;
        req = 1'b1; wr = 1'b0; f3 = 3'b010; addr = 32'h04; sdata = 32'h0;
        for (int c = 0; c < 40; c++) begin
            rdy = Ready;
            if (MemReadEnable && MemWriteEnable) overlap = 1'b1;
            if (Done) begin
                if (ndone == 0) begin done1 = c; ld1 = LoadData; end
                else begin done2 = c; ld2 = LoadData; end
                ndone++;
                if (ndone == 2) break;
            end
            @(posedge clk); #1;
            if (rdy && req) begin
                if (nacc == 0) begin acc1 = c + 1; addr = 32'h08; end
                else begin acc2 = c + 1; req = 1'b0; end
                nacc++;
            end
        end
        req = 1'b0;
        $display("b2b acc1=%0d done1=%0d ld1=%08h acc2=%0d done2=%0d ld2=%08h", acc1, done1, ld1, acc2, done2, ld2);
        checks++; if (done1 !== acc1 + 2 || acc1 < 0) begin
            errors++; $display("FAIL b2b_first_latency: got done at %0d expected %0d", done1, acc1 + 2); end
        checks++; if (acc2 !== done1 + 2 || done1 < 0) begin
            errors++; $display("FAIL b2b_accept: got second accept at %0d expected %0d", acc2, done1 + 2); end
        checks++; if (done2 !== acc2 + 2 || acc2 < 0) begin
            errors++; $display("FAIL b2b_second_latency: got done at %0d expected %0d", done2, acc2 + 2); end
        checks++; if (ld1 !== 32'h1 || ld2 !== 32'h2) begin
            errors++; $display("FAIL b2b_data: got %08h %08h expected 00000001 00000002", ld1, ld2); end
        checks++; if (overlap !== 1'b0) begin
            errors++; $display("FAIL b2b_overlap: got %0b expected 0", overlap); end
    endtask

    initial begin
        preload = 1'b1;
        rst_n = 1'b0;
        req = 1'b0; wr = 1'b0; f3 = 3'b000; addr = 32'h0; sdata = 32'h0;
        #2;
        test_reset;
        @(posedge clk); #1;
        preload = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_round_trip;
        test_extension;
        test_partial_store;
        test_faults;
        @(posedge clk); #1;
        test_reset_abort;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
